// File: rtl/multi_sel_core_pkg.sv
// Shared widths and phase encoding for the shift-add constant multiplier.
package multi_sel_core_pkg;
    localparam int DW = 8;
    localparam int OW = DW + 3;

    // cnt value selects which multiple of the sample is presented next
    typedef enum logic [1:0] {
        PH_X1 = 2'd0,
        PH_X3 = 2'd1,
        PH_X7 = 2'd2,
        PH_X8 = 2'd3
    } phase_t;
endpackage

// File: rtl/multi_sel_core_if.sv
// Producer/consumer bundle: byte in, grant strobe and product out.
interface multi_sel_core_if;
    import multi_sel_core_pkg::*;

    logic [DW-1:0] d;
    logic          input_grant;
    logic [OW-1:0] out;

    modport master (output d, input input_grant, input out);
    modport slave  (input d, output input_grant, output out);
endinterface

// File: rtl/multi_sel_core.sv
// Samples d every fourth cycle and presents d*1, d*3, d*7, d*8 on
// consecutive cycles using only shifts, adds and subtracts.
module multi_sel_core
    import multi_sel_core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    multi_sel_core_if.slave       bus
);
    phase_t        cnt_reg, cnt_next;
    logic [DW-1:0] d_reg, d_next;
    logic [OW-1:0] out_reg, out_next;
    logic          grant_reg, grant_next;

    logic [OW-1:0] ext;
    logic [OW-1:0] x3;
    logic [OW-1:0] x7;
    logic [OW-1:0] x8;

    // Widen before shifting so 8*(2^DW-1) survives; 8x - x never underflows
    assign ext = {3'b000, d_reg};
    assign x8  = ext << 3;
    assign x3  = (ext << 1) + ext;
    assign x7  = x8 - ext;

    always_comb begin
        cnt_next   = cnt_reg;
        d_next     = d_reg;
        out_next   = out_reg;
        grant_next = 1'b0;
        unique case (cnt_reg)
            PH_X1: begin
                d_next     = bus.d;
                out_next   = {3'b000, bus.d};
                grant_next = 1'b1;
                cnt_next   = PH_X3;
            end
            PH_X3: begin
                out_next = x3;
                cnt_next = PH_X7;
            end
            PH_X7: begin
                out_next = x7;
                cnt_next = PH_X8;
            end
            PH_X8: begin
                out_next = x8;
                cnt_next = PH_X1;
            end
            default: begin
                cnt_next = PH_X1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= PH_X1;
            d_reg     <= '0;
            out_reg   <= '0;
            grant_reg <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            d_reg     <= d_next;
            out_reg   <= out_next;
            grant_reg <= grant_next;
        end
    end

    assign bus.out         = out_reg;
    assign bus.input_grant = grant_reg;
endmodule

// File: tb/tb_multi_sel_core.sv
// Directed plus random stimulus against an arithmetic reference model of
// the 4-cycle multiply sequence.
module tb_multi_sel_core;
    logic clk;
    logic rst;
    multi_sel_core_if bus ();

    multi_sel_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: edges since reset, value captured on every 4th edge
    int          edge_idx = 0;
    int          sample   = 0;
    logic [31:0] exp_out  = 0;
    logic        exp_grant = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        edge_idx  = 0;
        sample    = 0;
        exp_out   = 0;
        exp_grant = 1'b0;
    endtask

    // Drive d, take one clock edge, then compare both outputs on the falling edge
    task automatic step(input logic [7:0] dval, input string tag);
        int k;
        int mult;
        bus.d = dval;
        @(posedge clk);
        k = edge_idx % 4;
        if (k == 0) sample = int'(dval);
        case (k)
            0: mult = 1;
            1: mult = 3;
            2: mult = 7;
            default: mult = 8;
        endcase
        exp_out   = 32'(sample * mult);
        exp_grant = (k == 0);
        edge_idx++;
        @(negedge clk);
        check({tag, "_out"}, {21'b0, bus.out}, exp_out);
        check({tag, "_grant"}, {31'b0, bus.input_grant}, {31'b0, exp_grant});
        $display("step %-10s d=%3d out=%4d grant=%0d", tag, dval, bus.out, bus.input_grant);
    endtask

    initial begin
        rst   = 1'b1;
        bus.d = 8'd143;
        model_reset();

        // Reset held across two edges
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_out", {21'b0, bus.out}, 32'd0);
            check("rst_hold_grant", {31'b0, bus.input_grant}, 32'd0);
        end
        rst = 1'b0;

        // Basic sequence with d held, wrapping into the next sample
        repeat (5) step(8'd143, "basic");
        step(8'd143, "basic");
        // now on phase 2 edge next: switch to 7, current sequence must finish
        step(8'd7, "chg");
        step(8'd7, "chg");
        repeat (4) step(8'd7, "chg_new");

        // Async reset while out is non-zero: clears before the next edge
        #2 rst = 1'b1;
        #1;
        check("async_out", {21'b0, bus.out}, 32'd0);
        check("async_grant", {31'b0, bus.input_grant}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        repeat (4) step(8'd0, "zero");
        repeat (4) step(8'd255, "max");
        step(8'd128, "b128");
        step(8'd128, "b128");
        step(8'd6, "toggle");
        step(8'd128, "toggle");
        repeat (4) step(8'd129, "toggle");

        // Reset during the x7 phase
        step(8'd50, "mid");
        step(8'd50, "mid");
        step(8'd50, "mid");
        check("mid_x7", {21'b0, bus.out}, 32'd350);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out", {21'b0, bus.out}, 32'd0);
        check("mid_rst_grant", {31'b0, bus.input_grant}, 32'd0);
        @(negedge clk);
        check("mid_rst_hold", {21'b0, bus.out}, 32'd0);
        rst = 1'b0;
        model_reset();
        step(8'd7, "post_rst");
        check("post_rst_first", {21'b0, bus.out}, 32'd7);

        // Random bytes every cycle; values in phases 1-3 must be ignored
        repeat (80) step(8'($urandom_range(0, 255)), "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
